memory_arbiter: RTL and testbench

Shares one pipelined, Avalon-style memory bus between the instruction-fetch port (driven by the text memory interface) and the data-access port of a core with unified instruction/data memory. Grants the bus per transaction with data-over-instruction priority. Holds the grant while the bus stalls. Tags every accepted read so the returning `bus_valid` beat is routed to the requester that issued it.

---
 rtl/memory_arbiter_pkg.sv | 23 ++
 rtl/tag_fifo.sv | 61 ++++++
 rtl/memory_arbiter.sv | 130 +++++++++++++
 tb/tb_memory_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and widths for the unified instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Tag remembered per accepted read so the returning beat finds its owner.
    typedef enum logic {
        TAG_INST,
        TAG_DATA
    } mem_tag_t;

    // Grant FSM: IDLE arbitrates freshly, HOLD_* pins the bus to a stalled winner.
    typedef enum logic [1:0] {
        IDLE,
        HOLD_INST,
        HOLD_DATA
    } grant_state_t;

endpackage

// File: rtl/tag_fifo.sv
// Small FIFO of 1-bit requester tags for outstanding bus reads.
// Latency: push visible at head one cycle later; head/full/empty are registered state.
// Backpressure: push while full and pop while empty are ignored; caller gates on full/empty.
// Ports: clock, reset (sync, active-high), push/push_tag, pop, full, empty, head.
module tag_fifo
    import memory_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  mem_tag_t push_tag,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output mem_tag_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    mem_tag_t        mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one pipelined memory bus between instruction fetch and data access (data wins),
// holding the grant across bus stalls and routing read beats back by issue-order tag.
// Latency: 0 cycles request-to-bus and bus-beat-to-requester. Backpressure: *_wait_req mirrors
// bus_wait_req for the granted side; the loser, and any read while the tag FIFO is full, waits.
// Ports: inst_* fetch port, data_* load/store port, bus_* shared memory bus; clock, reset.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inst_read_enable,
    input  logic [ADDR_W-1:0] inst_address,
    output logic              inst_wait_req,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    input  logic              data_read_enable,
    input  logic              data_write_enable,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] data_write_data,
    input  logic [BE_W-1:0]   data_byte_enable,
    output logic              data_wait_req,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_read_data,
    output logic              bus_read_enable,
    output logic              bus_write_enable,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_write_data,
    output logic [BE_W-1:0]   bus_byte_enable,
    input  logic              bus_wait_req,
    input  logic              bus_valid,
    input  logic [DATA_W-1:0] bus_read_data
);

    grant_state_t state;
    logic         fifo_full;
    logic         fifo_empty;
    mem_tag_t     fifo_head;
    logic         inst_req;
    logic         data_req;
    logic         grant_inst;
    logic         grant_data;
    logic         push;
    mem_tag_t     push_tag;
    logic         pop;

    // Full blocks reads even when a beat pops this cycle, keeping full off the bus_valid path.
    assign inst_req = inst_read_enable && !fifo_full;
    assign data_req = data_write_enable || (data_read_enable && !fifo_full);

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (data_req)      grant_data = 1'b1;
                    else if (inst_req) grant_inst = 1'b1;
                end
                HOLD_INST: grant_inst = inst_req;
                HOLD_DATA: grant_data = data_req;
                default:   ;
            endcase
        end
    end

    always_comb begin
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        bus_address      = '0;
        bus_write_data   = '0;
        bus_byte_enable  = '0;
        if (grant_inst) begin
            bus_read_enable  = 1'b1;
            bus_address      = inst_address;
            bus_byte_enable  = '1;
        end else if (grant_data) begin
            bus_read_enable  = data_read_enable;
            bus_write_enable = data_write_enable;
            bus_address      = data_address;
            bus_write_data   = data_write_data;
            bus_byte_enable  = data_byte_enable;
        end
    end

    assign inst_wait_req = !(grant_inst && !bus_wait_req);
    assign data_wait_req = !(grant_data && !bus_wait_req);

    assign push     = bus_read_enable && !bus_wait_req;
    assign push_tag = grant_data ? TAG_DATA : TAG_INST;
    assign pop      = bus_valid && !reset;

    // Beats with no outstanding tag (e.g. stragglers after reset) are swallowed.
    assign inst_valid     = pop && !fifo_empty && (fifo_head == TAG_INST);
    assign data_valid     = pop && !fifo_empty && (fifo_head == TAG_DATA);
    assign inst_data      = bus_read_data;
    assign data_read_data = bus_read_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_inst && bus_wait_req)      state <= HOLD_INST;
                    else if (grant_data && bus_wait_req) state <= HOLD_DATA;
                end
                // Release on acceptance or when the holder withdraws its request.
                HOLD_INST: if (!grant_inst || !bus_wait_req) state <= IDLE;
                HOLD_DATA: if (!grant_data || !bus_wait_req) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    tag_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    localparam int OUTST = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_read_enable;
    logic [31:0] inst_address;
    logic        inst_wait_req;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        data_read_enable;
    logic        data_write_enable;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [3:0]  data_byte_enable;
    logic        data_wait_req;
    logic        data_valid;
    logic [31:0] data_read_data;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_wait_req;
    logic        bus_valid;
    logic [31:0] bus_read_data;

    always #5 clock = ~clock;

    memory_arbiter #(.OUTSTANDING(OUTST)) dut (
        .clock             (clock),
        .reset             (reset),
        .inst_read_enable  (inst_read_enable),
        .inst_address      (inst_address),
        .inst_wait_req     (inst_wait_req),
        .inst_valid        (inst_valid),
        .inst_data         (inst_data),
        .data_read_enable  (data_read_enable),
        .data_write_enable (data_write_enable),
        .data_address      (data_address),
        .data_write_data   (data_write_data),
        .data_byte_enable  (data_byte_enable),
        .data_wait_req     (data_wait_req),
        .data_valid        (data_valid),
        .data_read_data    (data_read_data),
        .bus_read_enable   (bus_read_enable),
        .bus_write_enable  (bus_write_enable),
        .bus_address       (bus_address),
        .bus_write_data    (bus_write_data),
        .bus_byte_enable   (bus_byte_enable),
        .bus_wait_req      (bus_wait_req),
        .bus_valid         (bus_valid),
        .bus_read_data     (bus_read_data)
    );

    int tests = 0;
    int fails = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the bus (0 none, 1 inst, 2 data) and the
    // ordered list of owners of outstanding reads (0 inst, 1 data).
    int owner = 0;
    bit mq[$];
    bit exp_inst_acc = 1'b0;
    bit exp_data_acc = 1'b0;

    initial begin
        bit full, iok, dok, acc, exp_re, exp_we, ev_i, ev_d, rst_s, bv_s, bw_s;
        int w;
        forever begin
            @(negedge clock);
            rst_s = reset; bv_s = bus_valid; bw_s = bus_wait_req;
            full = (mq.size() == OUTST);
            w = 0; acc = 1'b0; exp_re = 1'b0; exp_we = 1'b0;
            if (rst_s) begin
                check1("rst_bus_re", bus_read_enable, 1'b0);
                check1("rst_bus_we", bus_write_enable, 1'b0);
                check1("rst_inst_wait", inst_wait_req, 1'b1);
                check1("rst_data_wait", data_wait_req, 1'b1);
                check1("rst_inst_valid", inst_valid, 1'b0);
                check1("rst_data_valid", data_valid, 1'b0);
            end else begin
                iok = inst_read_enable && !full;
                dok = data_write_enable || (data_read_enable && !full);
                case (owner)
                    1:       w = iok ? 1 : 0;
                    2:       w = dok ? 2 : 0;
                    default: w = dok ? 2 : (iok ? 1 : 0);
                endcase
                acc    = (w != 0) && !bw_s;
                exp_re = (w == 1) || (w == 2 && data_read_enable);
                exp_we = (w == 2) && data_write_enable;
                check1("bus_re", bus_read_enable, exp_re);
                check1("bus_we", bus_write_enable, exp_we);
                if (w == 1) begin
                    check32("bus_addr_i", bus_address, inst_address);
                    check32("bus_wd_i", bus_write_data, 32'h0);
                    check32("bus_be_i", {28'h0, bus_byte_enable}, 32'hF);
                end else if (w == 2) begin
                    check32("bus_addr_d", bus_address, data_address);
                    check32("bus_wd_d", bus_write_data, data_write_data);
                    check32("bus_be_d", {28'h0, bus_byte_enable}, {28'h0, data_byte_enable});
                end
                check1("inst_wait", inst_wait_req, !(w == 1 && acc));
                check1("data_wait", data_wait_req, !(w == 2 && acc));
                ev_i = bv_s && mq.size() > 0 && mq[0] == 1'b0;
                ev_d = bv_s && mq.size() > 0 && mq[0] == 1'b1;
                check1("inst_valid", inst_valid, ev_i);
                check1("data_valid", data_valid, ev_d);
            end
            check32("inst_data", inst_data, bus_read_data);
            check32("data_rdata", data_read_data, bus_read_data);
            exp_inst_acc = (w == 1) && acc;
            exp_data_acc = (w == 2) && acc;
            @(posedge clock);
            if (rst_s) begin
                mq.delete();
                owner = 0;
            end else begin
                if (bv_s && mq.size() > 0) void'(mq.pop_front());
                if (acc && exp_re) mq.push_back(w == 2);
                owner = (w != 0 && bw_s) ? w : 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        inst_read_enable = 0; inst_address = 0;
        data_read_enable = 0; data_write_enable = 0; data_address = 0;
        data_write_data = 0; data_byte_enable = 0;
        bus_wait_req = 0; bus_valid = 0; bus_read_data = 32'h1234;
        cyc(); cyc();
        neg();
        check1("reset_inst_wait", inst_wait_req, 1'b1);
        check1("reset_bus_re", bus_read_enable, 1'b0);
        cyc(); reset = 1'b0;

        // Simultaneous requests: data first, instruction next cycle.
        cyc(); inst_read_enable = 1; inst_address = 32'h0;
        data_read_enable = 1; data_address = 32'h100; data_byte_enable = 4'hF;
        neg();
        check32("t1_addr_data", bus_address, 32'h100);
        check1("t1_inst_wait", inst_wait_req, 1'b1);
        check1("t1_data_wait", data_wait_req, 1'b0);
        cyc(); data_read_enable = 0;
        neg();
        check32("t1_addr_inst", bus_address, 32'h0);
        check1("t1_inst_acc", inst_wait_req, 1'b0);
        cyc(); inst_read_enable = 0; bus_valid = 1; bus_read_data = 32'hAAAA;
        neg();
        check1("t1_dvalid", data_valid, 1'b1);
        check32("t1_ddata", data_read_data, 32'hAAAA);
        cyc(); bus_read_data = 32'hBBBB;
        neg();
        check1("t1_ivalid", inst_valid, 1'b1);
        check32("t1_idata", inst_data, 32'hBBBB);
        cyc(); bus_valid = 0;

        // Stalled instruction read keeps the bus; write follows acceptance.
        inst_read_enable = 1; inst_address = 32'h40; bus_wait_req = 1;
        cyc(); data_write_enable = 1; data_address = 32'h200;
        data_write_data = 32'h12345678; data_byte_enable = 4'hF;
        neg();
        check32("t2_addr_held", bus_address, 32'h40);
        check1("t2_no_write", bus_write_enable, 1'b0);
        cyc();
        cyc(); bus_wait_req = 0;
        neg();
        check1("t2_inst_acc", inst_wait_req, 1'b0);
        cyc(); inst_read_enable = 0;
        neg();
        check1("t2_write", bus_write_enable, 1'b1);
        check32("t2_waddr", bus_address, 32'h200);
        cyc(); data_write_enable = 0; bus_valid = 1; bus_read_data = 32'h55;
        cyc(); bus_valid = 0;

        // Fill the tag FIFO, then check the full rules.
        inst_read_enable = 1; inst_address = 32'h80;
        cyc(); inst_address = 32'h84;
        cyc(); inst_address = 32'h88; data_read_enable = 1; data_address = 32'h300;
        neg();
        check1("t3_full_iwait", inst_wait_req, 1'b1);
        check1("t3_full_dwait", data_wait_req, 1'b1);
        check1("t3_full_nore", bus_read_enable, 1'b0);
        cyc(); data_read_enable = 0; data_write_enable = 1; data_address = 32'h304;
        neg();
        check1("t3_full_write", bus_write_enable, 1'b1);
        cyc(); data_write_enable = 0; bus_valid = 1; bus_read_data = 32'h8080;
        neg();
        check1("t3_pop_ivalid", inst_valid, 1'b1);
        check1("t3_pop_still_wait", inst_wait_req, 1'b1);
        cyc(); bus_valid = 0;
        neg();
        check1("t3_next_acc", inst_wait_req, 1'b0);
        check32("t3_next_addr", bus_address, 32'h88);
        cyc(); inst_read_enable = 0; bus_valid = 1;

        // One outstanding: pop and push together.
        cyc(); data_read_enable = 1; data_address = 32'h400;
        neg();
        check1("t4_head_inst", inst_valid, 1'b1);
        check1("t4_data_acc", data_wait_req, 1'b0);
        cyc(); data_read_enable = 0; bus_read_data = 32'h4004;
        neg();
        check1("t4_then_data", data_valid, 1'b1);
        cyc(); bus_valid = 0;

        // Reset with two reads outstanding, stray beats afterwards.
        inst_read_enable = 1; inst_address = 32'h10;
        cyc(); inst_address = 32'h14;
        cyc(); inst_read_enable = 0; reset = 1; bus_valid = 1;
        data_write_enable = 1; data_address = 32'h20;
        neg();
        check1("t5_rst_ivalid", inst_valid, 1'b0);
        check1("t5_rst_dwait", data_wait_req, 1'b1);
        check1("t5_rst_nowrite", bus_write_enable, 1'b0);
        cyc(); reset = 0; data_write_enable = 0;
        neg();
        check1("t5_stray_ivalid", inst_valid, 1'b0);
        check1("t5_stray_dvalid", data_valid, 1'b0);
        cyc(); bus_valid = 0;

        // Partial write then read of the same address.
        data_write_enable = 1; data_address = 32'h500; data_byte_enable = 4'b0011;
        data_write_data = 32'hCAFEBABE;
        neg();
        check1("t6_write", bus_write_enable, 1'b1);
        check32("t6_wbe", {28'h0, bus_byte_enable}, 32'h3);
        cyc(); data_write_enable = 0; data_read_enable = 1;
        neg();
        check1("t6_read", bus_read_enable, 1'b1);
        check32("t6_rbe", {28'h0, bus_byte_enable}, 32'h3);
        cyc(); data_read_enable = 0; bus_valid = 1;
        cyc(); bus_valid = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset = ($urandom_range(0, 399) == 0);
            if (!inst_read_enable || exp_inst_acc) begin
                inst_read_enable = ($urandom_range(0, 2) != 0);
                inst_address = $urandom & 32'hFFFF_FFFC;
            end
            if (!(data_read_enable || data_write_enable) || exp_data_acc) begin
                r = $urandom_range(0, 4);
                data_read_enable  = (r == 1 || r == 2);
                data_write_enable = (r == 3);
                data_address      = $urandom & 32'hFFFF_FFFC;
                data_write_data   = $urandom;
                data_byte_enable  = 4'($urandom);
            end
            bus_wait_req  = ($urandom_range(0, 3) == 0);
            bus_read_data = $urandom;
            if (mq.size() > 0) bus_valid = ($urandom_range(0, 2) == 0);
            else               bus_valid = ($urandom_range(0, 49) == 0);
        end

        cyc();
        reset = 0; inst_read_enable = 0; data_read_enable = 0; data_write_enable = 0;
        bus_valid = 0; bus_wait_req = 0;
        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
